recovery_csr_restore_seq: RTL and testbench

- Restore-side sequencer for the rapid-recovery CSR backup storage.
- On a recovery request it reads each backed-up machine-mode CSR from the backup store in a fixed order. It writes each value into the core through a single-ported CSR write interface with a ready/valid handshake.
- It reports done, abort and ECC statistics to the recovery controller.
- It sits between the CSR backup store and the core's debug/recovery CSR write port.

---
 rtl/rapid_recovery_pkg.sv | 50 +++++
 rtl/recovery_csr_restore_seq.sv | 197 +++++++++++++++++++
 tb/tb_recovery_csr_restore_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rapid_recovery_pkg.sv
// Shared definitions for the rapid-recovery CSR restore sequencer:
// restore order, WARL masks, FSM state encoding and the ECC status type.
// Optional feature macro: RECOVERY_CSR_RESTORE_READBACK_EN (adds the CHECK state).
package rapid_recovery_pkg;

    localparam int RR_DATA_WIDTH     = 32;
    localparam int RR_CSR_ADDR_WIDTH = 12;
    localparam int RR_NUM_CSRS       = 7;
    localparam int RR_CNT_WIDTH      = 8;

    // ECC status from the backup store: bit 0 corrected, bit 1 uncorrectable
    typedef logic [1:0] ecc_err_t;
    localparam int ECC_CORR_BIT   = 0;
    localparam int ECC_UNCORR_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
        ST_CHECK = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } restore_state_e;

    // Restore order; MSTATUS goes last so interrupts stay off until everything else is back
    localparam logic [RR_CSR_ADDR_WIDTH-1:0] CSR_RESTORE_ADDR [RR_NUM_CSRS] = '{
        12'h305,  // MTVEC
        12'h340,  // MSCRATCH
        12'h341,  // MEPC
        12'h342,  // MCAUSE
        12'h344,  // MIP
        12'h304,  // MIE
        12'h300   // MSTATUS
    };

    // Bits that read back as written; the rest are WARL and may legally differ
    localparam logic [RR_DATA_WIDTH-1:0] CSR_RESTORE_MASK [RR_NUM_CSRS] = '{
        32'hFFFF_FFFD,  // MTVEC: reserved mode encoding not retained
        32'hFFFF_FFFF,  // MSCRATCH
        32'hFFFF_FFFE,  // MEPC: bit 0 always zero
        32'h8000_001F,  // MCAUSE: interrupt flag and implemented code bits
        32'h0000_0888,  // MIP
        32'h0000_0888,  // MIE
        32'h0000_1888   // MSTATUS: MIE, MPIE, MPP
    };

endpackage

// File: rtl/recovery_csr_restore_seq.sv
// Restore-side sequencer: reads backed-up machine-mode CSRs one by one and
// writes them into the core over a ready/valid CSR write port.
// Optional feature macro: RECOVERY_CSR_RESTORE_READBACK_EN (read-back verify with one retry).
module recovery_csr_restore_seq
    import rapid_recovery_pkg::*;
#(
    parameter int  DataWidth    = RR_DATA_WIDTH,
    parameter int  CsrAddrWidth = RR_CSR_ADDR_WIDTH,
    parameter int  NumCsrs      = RR_NUM_CSRS,
    parameter int  CntWidth     = RR_CNT_WIDTH,
    localparam int IdxWidth     = $clog2(NumCsrs)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    abort_o,
    output logic                    bkp_rd_en_o,
    output logic [IdxWidth-1:0]     bkp_idx_o,
    input  logic [DataWidth-1:0]    bkp_rdata_i,
    input  logic [1:0]              bkp_err_i,
    output logic                    csr_we_o,
    output logic [CsrAddrWidth-1:0] csr_addr_o,
    output logic [DataWidth-1:0]    csr_wdata_o,
    input  logic                    csr_gnt_i,
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
    output logic                    csr_re_o,
    input  logic [DataWidth-1:0]    csr_rdata_i,
    input  logic                    csr_rvalid_i,
`endif
    output logic [CntWidth-1:0]     corr_cnt_o
);

    restore_state_e          r_state;
    logic [IdxWidth-1:0]     r_idx;
    logic [CntWidth-1:0]     r_corr_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_abort;
    logic                    r_bkp_rd_en;
    logic [IdxWidth-1:0]     r_bkp_idx;
    logic                    r_csr_we;
    logic [CsrAddrWidth-1:0] r_csr_addr;
    logic [DataWidth-1:0]    r_csr_wdata;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
    logic                    r_csr_re;
    logic [DataWidth-1:0]    r_data;
    logic                    r_retried;
    logic                    w_match;
`endif

    ecc_err_t                w_err;
    logic [CsrAddrWidth-1:0] w_tbl_addr;
    logic                    w_last;

    assign w_err      = bkp_err_i;
    assign w_tbl_addr = CsrAddrWidth'(CSR_RESTORE_ADDR[r_idx]);
    assign w_last     = (r_idx == IdxWidth'(NumCsrs - 1));
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
    assign w_match    = (((csr_rdata_i ^ r_data) & DataWidth'(CSR_RESTORE_MASK[r_idx])) == '0);
`endif

    // Single FSM: state, index, counter and every output are registered together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_corr_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_bkp_rd_en <= 1'b0;
            r_bkp_idx   <= '0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
            r_csr_re    <= 1'b0;
            r_data      <= '0;
            r_retried   <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_bkp_rd_en <= 1'b0;
            r_bkp_idx   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state     <= ST_READ;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_corr_cnt  <= '0;
                        r_bkp_rd_en <= 1'b1;
                        r_bkp_idx   <= '0;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
                        r_retried   <= 1'b0;
`endif
                    end
                end
                ST_READ: begin
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (w_err[ECC_UNCORR_BIT]) begin
                        r_state <= ST_ABORT;
                        r_abort <= 1'b1;
                    end else begin
                        if (w_err[ECC_CORR_BIT] && (r_corr_cnt != '1)) begin
                            r_corr_cnt <= r_corr_cnt + CntWidth'(1);
                        end
                        r_state     <= ST_WRITE;
                        r_csr_we    <= 1'b1;
                        r_csr_addr  <= w_tbl_addr;
                        r_csr_wdata <= bkp_rdata_i;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
                        r_data      <= bkp_rdata_i;
`endif
                    end
                end
                ST_WRITE: begin
                    if (csr_gnt_i) begin
                        r_csr_we    <= 1'b0;
                        r_csr_wdata <= '0;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
                        r_state     <= ST_CHECK;
                        r_csr_re    <= 1'b1;
`else
                        r_csr_addr  <= '0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx       <= r_idx + IdxWidth'(1);
                            r_state     <= ST_READ;
                            r_bkp_rd_en <= 1'b1;
                            r_bkp_idx   <= r_idx + IdxWidth'(1);
                        end
`endif
                    end
                end
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
                ST_CHECK: begin
                    if (csr_rvalid_i) begin
                        r_csr_re <= 1'b0;
                        if (w_match) begin
                            r_csr_addr <= '0;
                            r_retried  <= 1'b0;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx       <= r_idx + IdxWidth'(1);
                                r_state     <= ST_READ;
                                r_bkp_rd_en <= 1'b1;
                                r_bkp_idx   <= r_idx + IdxWidth'(1);
                            end
                        end else if (!r_retried) begin
                            r_retried   <= 1'b1;
                            r_state     <= ST_WRITE;
                            r_csr_we    <= 1'b1;
                            r_csr_wdata <= r_data;
                        end else begin
                            r_csr_addr <= '0;
                            r_state    <= ST_ABORT;
                            r_abort    <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ABORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign abort_o     = r_abort;
    assign bkp_rd_en_o = r_bkp_rd_en;
    assign bkp_idx_o   = r_bkp_idx;
    assign csr_we_o    = r_csr_we;
    assign csr_addr_o  = r_csr_addr;
    assign csr_wdata_o = r_csr_wdata;
    assign corr_cnt_o  = r_corr_cnt;
`ifdef RECOVERY_CSR_RESTORE_READBACK_EN
    assign csr_re_o    = r_csr_re;
`endif

endmodule

// File: tb/tb_recovery_csr_restore_seq.sv
// Self-checking bench for recovery_csr_restore_seq (default build, read-back feature off).
// A restore-order model fills scoreboard queues; a negedge monitor consumes them.
module tb_recovery_csr_restore_seq;

    localparam int N = 7;
    localparam logic [11:0] TBL [N] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h304, 12'h300};

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, abort_o, bkp_rd_en_o;
    logic [2:0]  bkp_idx_o;
    logic [31:0] bkp_rdata_i = '0;
    logic [1:0]  bkp_err_i = '0;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_gnt_i = 1'b1;
    logic [7:0]  corr_cnt_o;

    recovery_csr_restore_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .abort_o     (abort_o),
        .bkp_rd_en_o (bkp_rd_en_o),
        .bkp_idx_o   (bkp_idx_o),
        .bkp_rdata_i (bkp_rdata_i),
        .bkp_err_i   (bkp_err_i),
        .csr_we_o    (csr_we_o),
        .csr_addr_o  (csr_addr_o),
        .csr_wdata_o (csr_wdata_o),
        .csr_gnt_i   (csr_gnt_i),
        .corr_cnt_o  (corr_cnt_o)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit isAbort;
        int baseCyc;
        int corr;
    } ev_t;

    wr_t         expWrQ [$];
    ev_t         expEvQ [$];
    int          expRdQ [$];
    logic [31:0] mem [N];
    logic [1:0]  errMem [N];
    int          nChecks = 0;
    int          nFails = 0;
    int          cyc = 0;
    int          stalls = 0;
    bit          endSeen = 1'b0;
    logic [11:0] stallAddr = '0;
    int          stallLeft = 0;
    int          rdIdx = 0;

    always #5 clk_i = ~clk_i;

    // Free-running cycle counter used to time done/abort relative to start
    always @(posedge clk_i) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] act);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Backup store model: data and ECC status appear the cycle after the read strobe
    always @(negedge clk_i) begin
        if (bkp_rd_en_o) begin
            rdIdx = int'(bkp_idx_o);
            @(posedge clk_i);
            #1;
            bkp_rdata_i = (rdIdx < N) ? mem[rdIdx] : 32'hBAD0_BAD0;
            bkp_err_i   = (rdIdx < N) ? errMem[rdIdx] : 2'b00;
            @(posedge clk_i);
            #1;
            bkp_rdata_i = $urandom;
            bkp_err_i   = 2'b00;
        end
    end

    // Core grant model: withholds grant for a set number of cycles on one chosen CSR
    always @(posedge clk_i) begin
        #1;
        if (stallLeft > 0 && csr_we_o && csr_addr_o == stallAddr) begin
            csr_gnt_i = 1'b0;
            stallLeft--;
        end else begin
            csr_gnt_i = 1'b1;
        end
    end

    // Monitor: checks reads, writes (including held values during backpressure) and end events
    always @(negedge clk_i) begin
        if (bkp_rd_en_o) begin
            if (expRdQ.size() == 0) reportUnexpected("unexpected backup read", bkp_idx_o);
            else checkOutput("backup read index", bkp_idx_o, expRdQ.pop_front());
        end else begin
            checkOutput("bkp_idx idle", bkp_idx_o, 0);
        end
        if (csr_we_o) begin
            if (expWrQ.size() == 0) begin
                reportUnexpected("unexpected csr write", csr_addr_o);
            end else begin
                checkOutput("csr write addr", csr_addr_o, expWrQ[0].addr);
                checkOutput("csr write data", csr_wdata_o, expWrQ[0].data);
                if (csr_gnt_i) void'(expWrQ.pop_front());
                else stalls++;
            end
        end else begin
            checkOutput("csr addr idle", csr_addr_o, 0);
            checkOutput("csr wdata idle", csr_wdata_o, 0);
        end
        if (done_o || abort_o) begin
            if (expEvQ.size() == 0) begin
                reportUnexpected("unexpected done/abort", {abort_o, done_o});
            end else begin
                ev_t ev;
                ev = expEvQ.pop_front();
                checkOutput("abort pulse", abort_o, ev.isAbort);
                checkOutput("done pulse", done_o, !ev.isAbort);
                checkOutput("end cycle", cyc, ev.baseCyc + stalls);
                checkOutput("corr_cnt at end", corr_cnt_o, ev.corr);
                checkOutput("busy during end", busy_o, 1);
            end
            endSeen = 1'b1;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, busy_o, 0);
        checkOutput({tag, " done"}, done_o, 0);
        checkOutput({tag, " abort"}, abort_o, 0);
        checkOutput({tag, " rd_en"}, bkp_rd_en_o, 0);
        checkOutput({tag, " bkp_idx"}, bkp_idx_o, 0);
        checkOutput({tag, " we"}, csr_we_o, 0);
        checkOutput({tag, " addr"}, csr_addr_o, 0);
        checkOutput({tag, " wdata"}, csr_wdata_o, 0);
        checkOutput({tag, " corr_cnt"}, corr_cnt_o, 0);
    endtask

    // Pulse start, fill the scoreboard from the restore rules, optionally wait for the end
    task automatic applyStimulus(input logic [11:0] sAddr, input int sLen, input int extraAt, input bit waitEnd);
        int corr;
        int startCyc;
        int k;
        bit aborted;
        corr      = 0;
        aborted   = 1'b0;
        k         = 0;
        stallAddr = sAddr;
        stallLeft = sLen;
        stalls    = 0;
        endSeen   = 1'b0;
        @(posedge clk_i);
        #1;
        start_i  = 1'b1;
        startCyc = cyc;
        for (int i = 0; i < N; i++) begin
            expRdQ.push_back(i);
            if (errMem[i][1]) begin
                expEvQ.push_back('{1'b1, startCyc + 3 + 3 * i, corr});
                aborted = 1'b1;
                break;
            end
            if (errMem[i][0] && corr < 255) corr++;
            expWrQ.push_back('{TBL[i], mem[i]});
        end
        if (!aborted) expEvQ.push_back('{1'b0, startCyc + 3 * N + 1, corr});
        do begin
            @(posedge clk_i);
            #1;
            k++;
            start_i = (k == extraAt);
            if (k == 1) checkOutput("busy after start", busy_o, 1);
        end while (waitEnd && !endSeen && k < 300);
        if (!waitEnd) return;
        start_i = 1'b0;
        if (!endSeen) reportUnexpected("timeout waiting for done/abort", k);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("busy after end", busy_o, 0);
        checkOutput("leftover writes", expWrQ.size(), 0);
        checkOutput("leftover reads", expRdQ.size(), 0);
        checkOutput("leftover end events", expEvQ.size(), 0);
        checkOutput("corr_cnt held", corr_cnt_o, corr);
    endtask

    initial begin
        int waitK;
        for (int i = 0; i < N; i++) errMem[i] = 2'b00;
        mem = '{32'h1000_0000, 32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_000B,
                32'h0000_0000, 32'h0000_0888, 32'h0000_1888};

        repeat (2) @(posedge clk_i);
        #1;
        checkAllZero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        $display("[TB] nominal restore");
        applyStimulus(12'h000, 0, 0, 1'b1);

        $display("[TB] backpressure on MEPC");
        applyStimulus(12'h341, 5, 0, 1'b1);

        $display("[TB] corrected errors on entries 1 and 4");
        errMem[1] = 2'b01;
        errMem[4] = 2'b01;
        applyStimulus(12'h000, 0, 0, 1'b1);

        $display("[TB] uncorrectable error on MCAUSE");
        for (int i = 0; i < N; i++) errMem[i] = 2'b00;
        errMem[3] = 2'b10;
        applyStimulus(12'h000, 0, 0, 1'b1);
        errMem[3] = 2'b00;

        $display("[TB] start while busy and start on the done cycle");
        applyStimulus(12'h000, 0, 8, 1'b1);
        applyStimulus(12'h000, 0, 3 * N + 1, 1'b1);

        $display("[TB] reset during stalled MIP write");
        applyStimulus(12'h344, 50, 0, 1'b0);
        waitK = 0;
        while (!(csr_we_o && csr_addr_o == 12'h344) && waitK < 100) begin
            @(posedge clk_i);
            #1;
            waitK++;
        end
        if (waitK >= 100) reportUnexpected("timeout waiting for MIP write", waitK);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checkAllZero("mid-run reset");
        expWrQ.delete();
        expRdQ.delete();
        expEvQ.delete();
        stallLeft = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(12'h000, 0, 0, 1'b1);

        $display("[TB] randomized restores");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                int pick;
                mem[i] = $urandom;
                pick   = $urandom_range(0, 19);
                errMem[i] = (pick < 4) ? 2'b01 : (pick == 4) ? 2'b10 : (pick == 5) ? 2'b11 : 2'b00;
            end
            applyStimulus(TBL[$urandom_range(0, N - 1)], $urandom_range(0, 4), 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
